// File: rtl/systolic_mac_stage_ctrl.sv
// Weight staging, data launch and output deskew around a row of NCOL = TOUT/TN PE columns (NCOL >= 2).
// Define SYSTOLIC_STAGE_ERR_EN to build the sticky double-underrun error flag; otherwise err is tied low.
module systolic_mac_stage_ctrl #(
  parameter int  TOUT     = 32,
  parameter int  TN       = 4,
  parameter int  BASE_TIN = 64,
  parameter int  DAT_DW   = 8,
  parameter int  WT_DW    = 8,
  parameter int  ACC_DW   = 20,
  parameter int  PE_LAT   = 3,
  localparam int NCOL     = TOUT / TN,
  localparam int CNT_W    = $clog2(TOUT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [3:0]                        Tin_factor,
  input  logic                              dat_vld,
  input  logic [BASE_TIN*DAT_DW-1:0]        dat,
  input  logic                              Wout_loop_start,
  input  logic                              Wout_loop_end,
  input  logic                              wt_vld,
  input  logic [BASE_TIN*WT_DW-1:0]         wt,
  input  logic [CNT_W-1:0]                  wt_cnt,
  output logic                              wt_rdy,
  output logic [BASE_TIN*DAT_DW-1:0]        col_dat,
  output logic [NCOL*TN*BASE_TIN*WT_DW-1:0] col_wt,
  output logic [NCOL*4-1:0]                 col_tin,
  input  logic [NCOL*TN*ACC_DW-1:0]         col_res,
  output logic [TOUT*ACC_DW-1:0]            dat_o,
  output logic                              dat_o_vld,
  output logic                              dat_o_last,
  output logic                              err
);

  localparam int WW   = BASE_TIN * WT_DW;
  localparam int CW   = TN * WW;
  localparam int RW   = TN * ACC_DW;
  localparam int VLAT = 1 + PE_LAT + NCOL;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOUT - 1);

  logic                       wt_acc;
  logic                       promote;
  logic                       s1_full_q, s1_full_d;
  logic                       wait_wt_q, wait_wt_d;
  logic [WW-1:0]              s1_bank_q [TOUT];
  logic [WW-1:0]              s1_bank_d [TOUT];
  logic [TOUT*WW-1:0]         s2_bank_q, s2_bank_d;
  logic [NCOL-2:0]            prom_dly_q, prom_dly_d;
  logic [VLAT-1:0]            vld_pipe_q, vld_pipe_d;
  logic [VLAT-1:0]            last_pipe_q, last_pipe_d;
  logic [BASE_TIN*DAT_DW-1:0] col_dat_q, col_dat_d;
  logic [NCOL*4-1:0]          col_tin_q, col_tin_d;

  // A loop start with no complete set parks in wait_wt; the set promotes the cycle after it completes.
  always_comb begin
    wt_acc    = wt_vld & ~s1_full_q;
    promote   = ~flush & s1_full_q & (Wout_loop_start | wait_wt_q);
    s1_full_d = s1_full_q;
    wait_wt_d = wait_wt_q;
    if (flush) begin
      s1_full_d = 1'b0;
      wait_wt_d = 1'b0;
    end else begin
      if (promote) begin
        s1_full_d = 1'b0;
      end else if (wt_acc && (wt_cnt == LAST_CNT)) begin
        s1_full_d = 1'b1;
      end
      if (promote) begin
        wait_wt_d = 1'b0;
      end else if (Wout_loop_start && !s1_full_q) begin
        wait_wt_d = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TOUT; i++) begin
      s1_bank_d[i] = s1_bank_q[i];
      if (wt_acc && (wt_cnt == CNT_W'(i))) s1_bank_d[i] = wt;
    end
    s2_bank_d = s2_bank_q;
    if (promote) begin
      for (int i = 0; i < TOUT; i++) s2_bank_d[i*WW +: WW] = s1_bank_q[i];
    end
  end

  // Bit k marks a promote k+1 cycles ago; column k+1 reloads its bank then.
  always_comb begin
    prom_dly_d = '0;
    if (!flush) begin
      prom_dly_d[0] = promote;
      for (int k = 1; k < NCOL - 1; k++) prom_dly_d[k] = prom_dly_q[k-1];
    end
    vld_pipe_d  = flush ? '0 : {vld_pipe_q[VLAT-2:0], dat_vld};
    last_pipe_d = flush ? '0 : {last_pipe_q[VLAT-2:0], dat_vld & Wout_loop_end};
    col_dat_d   = dat_vld ? dat : col_dat_q;
    col_tin_d   = {NCOL{Tin_factor}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_q   <= 1'b0;
      wait_wt_q   <= 1'b0;
      for (int i = 0; i < TOUT; i++) s1_bank_q[i] <= '0;
      s2_bank_q   <= '0;
      prom_dly_q  <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      col_dat_q   <= '0;
      col_tin_q   <= '0;
    end else begin
      s1_full_q   <= s1_full_d;
      wait_wt_q   <= wait_wt_d;
      for (int i = 0; i < TOUT; i++) s1_bank_q[i] <= s1_bank_d[i];
      s2_bank_q   <= s2_bank_d;
      prom_dly_q  <= prom_dly_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      col_dat_q   <= col_dat_d;
      col_tin_q   <= col_tin_d;
    end
  end

  assign col_wt[CW-1:0] = s2_bank_q[CW-1:0];

  for (genvar n = 1; n < NCOL; n++) begin : g_col
    logic [CW-1:0] bank_q, bank_d;

    always_comb bank_d = prom_dly_q[n-1] ? s2_bank_q[n*CW +: CW] : bank_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bank_q <= '0;
      else        bank_q <= bank_d;
    end

    assign col_wt[n*CW +: CW] = bank_q;
  end

  // Column n lags column 0 by n cycles, so it gets NCOL-n stages to line everything up.
  for (genvar n = 0; n < NCOL; n++) begin : g_dsk
    localparam int D = NCOL - n;
    logic [RW-1:0] dsk_q [D];
    logic [RW-1:0] dsk_d [D];

    always_comb begin
      dsk_d[0] = col_res[n*RW +: RW];
      for (int k = 1; k < D; k++) dsk_d[k] = dsk_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < D; k++) dsk_q[k] <= '0;
      end else begin
        for (int k = 0; k < D; k++) dsk_q[k] <= dsk_d[k];
      end
    end

    assign dat_o[n*RW +: RW] = dsk_q[D-1];
  end

`ifdef SYSTOLIC_STAGE_ERR_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (~flush & Wout_loop_start & wait_wt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign wt_rdy     = ~s1_full_q;
  assign col_dat    = col_dat_q;
  assign col_tin    = col_tin_q;
  assign dat_o_vld  = vld_pipe_q[VLAT-1];
  assign dat_o_last = last_pipe_q[VLAT-1];

endmodule

// File: tb/tb_systolic_mac_stage_ctrl.sv
// Directed bench for systolic_mac_stage_ctrl with TOUT=8, TN=2 (four columns), PE_LAT=3.
module tb_systolic_mac_stage_ctrl;
  localparam int TOUT = 8, TN = 2, BASE_TIN = 4, DAT_DW = 8, WT_DW = 8, ACC_DW = 20, PE_LAT = 3;
  localparam int NCOL = TOUT / TN;
  localparam int WW   = BASE_TIN * WT_DW;
`ifdef SYSTOLIC_STAGE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b1;
  logic                          flush = 1'b0;
  logic [3:0]                    Tin_factor = '0;
  logic                          dat_vld = 1'b0;
  logic [BASE_TIN*DAT_DW-1:0]    dat = '0;
  logic                          Wout_loop_start = 1'b0;
  logic                          Wout_loop_end = 1'b0;
  logic                          wt_vld = 1'b0;
  logic [BASE_TIN*WT_DW-1:0]     wt = '0;
  logic [2:0]                    wt_cnt = '0;
  logic                          wt_rdy;
  logic [BASE_TIN*DAT_DW-1:0]    col_dat;
  logic [TOUT*WW-1:0]            col_wt;
  logic [NCOL*4-1:0]             col_tin;
  logic [TOUT*ACC_DW-1:0]        col_res = '0;
  logic [TOUT*ACC_DW-1:0]        dat_o;
  logic                          dat_o_vld;
  logic                          dat_o_last;
  logic                          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_mac_stage_ctrl #(
    .TOUT(TOUT), .TN(TN), .BASE_TIN(BASE_TIN), .DAT_DW(DAT_DW),
    .WT_DW(WT_DW), .ACC_DW(ACC_DW), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .Tin_factor(Tin_factor),
    .dat_vld(dat_vld), .dat(dat), .Wout_loop_start(Wout_loop_start),
    .Wout_loop_end(Wout_loop_end), .wt_vld(wt_vld), .wt(wt), .wt_cnt(wt_cnt),
    .wt_rdy(wt_rdy), .col_dat(col_dat), .col_wt(col_wt), .col_tin(col_tin),
    .col_res(col_res), .dat_o(dat_o), .dat_o_vld(dat_o_vld),
    .dat_o_last(dat_o_last), .err(err)
  );

  typedef struct {
    logic wv; int cnt; int base; logic ls;
    logic rdy; int c0; int c2; int c7;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic wv, int cnt, int base, logic ls,
                               logic rdy, int c0, int c2, int c7);
    vec_t v;
    v.wv = wv; v.cnt = cnt; v.base = base; v.ls = ls;
    v.rdy = rdy; v.c0 = c0; v.c2 = c2; v.c7 = c7;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Lowest byte of channel ch's weight word as presented to the columns.
  function automatic logic [7:0] wb(input int ch);
    return col_wt[ch*WW +: 8];
  endfunction

  // Called at a negedge: drive one cycle of weight/control inputs, return at the next negedge.
  task automatic step(input logic wv, input int cnt, input int base, input logic ls, input logic fl);
    wt_vld          = wv;
    wt_cnt          = 3'(cnt);
    wt              = {BASE_TIN{8'(base + cnt)}};
    Wout_loop_start = ls;
    flush           = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: set ready, start 5 cycles later. Scenario 2: start first, weights 10 cycles later.
    for (int i = 0; i < 8; i++) tbl.push_back(mkv(1, i, 'h10, 0, i != 7, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 'h10, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h10, 'h12, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h10, 'h12, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h10, 'h12, 'h17));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 'h10, 'h12, 'h17));
    for (int i = 0; i < 9; i++) tbl.push_back(mkv(0, 0, 0, 0, 1, 'h10, 'h12, 'h17));
    for (int i = 0; i < 8; i++) tbl.push_back(mkv(1, i, 'h20, 0, i != 7, 'h10, 'h12, 'h17));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h20, 'h12, 'h17));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h20, 'h22, 'h17));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h20, 'h22, 'h17));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 'h20, 'h22, 'h27));

    #1 rst_n = 1'b0;
    #20;
    chk("reset wt_rdy", wt_rdy, 1'b1);
    chk("reset err", err, 1'b0);
    chk("reset dat_o_vld", dat_o_vld, 1'b0);
    chk("reset dat_o_last", dat_o_last, 1'b0);
    chk("reset col_wt zero", col_wt == '0, 1'b1);
    chk("reset dat_o zero", dat_o == '0, 1'b1);
    chk("reset col_dat", col_dat, 0);
    chk("reset col_tin", col_tin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].wv, tbl[r].cnt, tbl[r].base, tbl[r].ls, 1'b0);
      chk($sformatf("tbl%0d wt_rdy", r), wt_rdy, tbl[r].rdy);
      chk($sformatf("tbl%0d ch0", r), wb(0), 8'(tbl[r].c0));
      chk($sformatf("tbl%0d ch2", r), wb(2), 8'(tbl[r].c2));
      chk($sformatf("tbl%0d ch7", r), wb(7), 8'(tbl[r].c7));
    end
    chk("s2 err after single underrun", err, 1'b0);

    // Scenario 3: two starts with no weights, then one set -> exactly one promote.
    step(0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    chk("s3 double underrun err", err, ERR_EXP);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      step(1, i, 'h30, 0, 0);
      chk($sformatf("s3 rdy w%0d", i), wt_rdy, i != 7);
    end
    idle(1);
    chk("s3 rdy after promote", wt_rdy, 1'b1);
    chk("s3 ch0 promoted", wb(0), 8'h30);

    // Scenario 5: second set held back by wt_rdy until the next start; no overwrite.
    for (int i = 0; i < 8; i++) begin
      step(1, i, 'h40, 0, 0);
      chk($sformatf("s5 rdy w%0d", i), wt_rdy, i != 7);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 'h55, 0, 0);
      chk("s5 rdy held", wt_rdy, 1'b0);
      chk("s5 ch0 held", wb(0), 8'h30);
    end
    step(0, 0, 0, 1, 0);
    chk("s5 rdy on start", wt_rdy, 1'b1);
    chk("s5 ch0 on start", wb(0), 8'h40);
    chk("s5 ch1 on start", wb(1), 8'h41);
    idle(3);
    chk("s5 ch7 after 4", wb(7), 8'h47);
    chk("s5 err sticky", err, ERR_EXP);

    // Tin fanout registers.
    Tin_factor = 4'd4;
    idle(1);
    chk("col_tin 4", col_tin, {NCOL{4'd4}});
    Tin_factor = 4'd8;
    idle(1);
    chk("col_tin 8", col_tin, {NCOL{4'd8}});

    // Scenario 4: burst of 6, last on the 6th, time-tagged column results.
    for (int k = 0; k < 20; k++) begin
      bit ev;
      ev = (k >= 10) && (k <= 15);
      chk($sformatf("s4 vld k%0d", k), dat_o_vld, ev);
      chk($sformatf("s4 last k%0d", k), dat_o_last, k == 15);
      if (ev) begin
        for (int c = 0; c < TOUT; c++)
          chk($sformatf("s4 dat_o k%0d ch%0d", k, c), dat_o[c*ACC_DW +: ACC_DW], 20'((k - 8) * 16 + c));
      end
      if (k == 3)  chk("s4 col_dat first", col_dat, {BASE_TIN{8'(2 + 'hA0)}});
      if (k == 12) chk("s4 col_dat hold", col_dat, {BASE_TIN{8'(7 + 'hA0)}});
      dat_vld       = (k >= 2) && (k <= 7);
      Wout_loop_end = (k == 7) || (k == 9);
      dat           = {BASE_TIN{8'(k + 'hA0)}};
      for (int n = 0; n < NCOL; n++)
        for (int j = 0; j < TN; j++)
          col_res[(n*TN + j)*ACC_DW +: ACC_DW] = 20'((k - (1 + PE_LAT + n)) * 16 + n*TN + j);
      @(negedge clk);
    end
    dat_vld = 1'b0;
    Wout_loop_end = 1'b0;

    // Scenario 6: flush mid-load with pending wait_wt and in-flight valids.
    step(0, 0, 0, 1, 0);
    dat_vld = 1'b1;
    step(1, 0, 'h50, 0, 0);
    step(1, 1, 'h50, 0, 0);
    dat_vld = 1'b0;
    step(1, 2, 'h50, 0, 0);
    step(1, 3, 'h50, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("s6 rdy after flush", wt_rdy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1, i, 'h60, 0, 0);
      chk($sformatf("s6 rdy w%0d", i), wt_rdy, i != 7);
      chk($sformatf("s6 no stale vld w%0d", i), dat_o_vld, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("s6 no promote after flush", wt_rdy, 1'b0);
      chk("s6 ch0 unchanged", wb(0), 8'h40);
      chk("s6 no stale vld", dat_o_vld, 1'b0);
    end
    step(0, 0, 0, 0, 1);
    chk("s6 flush clears full", wt_rdy, 1'b1);
    for (int i = 0; i < 8; i++) step(1, i, 'h70, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("s6 ch0 new set", wb(0), 8'h70);
    chk("s6 ch1 new set", wb(1), 8'h71);
    idle(3);
    chk("s6 ch2 new set", wb(2), 8'h72);
    chk("s6 ch7 new set", wb(7), 8'h77);
    chk("s6 err survives flush", err, ERR_EXP);

    // Async reset with a full stage1 bank.
    for (int i = 0; i < 8; i++) step(1, i, 'h80, 0, 0);
    chk("ar rdy before reset", wt_rdy, 1'b0);
    wt_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar rdy", wt_rdy, 1'b1);
    chk("ar col_wt zero", col_wt == '0, 1'b1);
    chk("ar err", err, 1'b0);
    chk("ar col_tin", col_tin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) step(1, i, 'h90, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("ar post-reset ch0", wb(0), 8'h90);
    chk("ar post-reset ch1", wb(1), 8'h91);
    chk("ar post-reset rdy", wt_rdy, 1'b1);
    idle(3);
    chk("ar post-reset ch5", wb(5), 8'h95);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_mac_stage_ctrl.md
# systolic_mac_stage_ctrl

Parametrised weight-staging, data-launch and output-deskew controller for one column-systolic MAC array. It sits between the weight/feature buffers and a row of NCOL = TOUT/TN PE columns. It adds three things: a backpressured double-buffered weight path, loop-start/weight-arrival arbitration, and aligned output valid/last tracking. PE arithmetic stays in the columns; this block owns all timing around them.

## Interface
- TOUT, 32, output channels; power of two
- TN, 4, output channels per PE column; divides TOUT
- BASE_TIN, 64, input lanes
- DAT_DW, 8, feature bits per lane
- WT_DW, 8, weight bits per lane
- ACC_DW, 20, result bits per output channel
- PE_LAT, 3, PE column latency, left-data-in to down-out, ≥1

- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  sync clear of staging state and valid pipelines
- Tin_factor  in  4  1/2/4/8 = 8/4/2/1-bit mode
- dat_vld  in  1  feature word valid
- dat  in  BASE_TIN*DAT_DW  feature word
- Wout_loop_start  in  1  pulse, binds a weight set to a new Wout loop
- Wout_loop_end  in  1  pulse, last feature word of the loop (qualified by dat_vld)
- wt_vld  in  1  weight word valid
- wt  in  BASE_TIN*WT_DW  one output channel's weights
- wt_cnt  in  log2(TOUT)  channel index of wt
- wt_rdy  out  1  weight word accepted when wt_vld&wt_rdy
- col_dat  out  BASE_TIN*DAT_DW  to column 0 left input
- col_wt  out  NCOL*TN*BASE_TIN*WT_DW  column n at slice n
- col_tin  out  NCOL*4  registered Tin_factor per column
- col_res  in  NCOL*TN*ACC_DW  column down outputs
- dat_o  out  TOUT*ACC_DW  deskewed results, channel c at slice c
- dat_o_vld  out  1  dat_o valid
- dat_o_last  out  1  last result of loop
- err  out  1  sticky weight-underrun error

## Operation
- Stage1 bank of TOUT words: word i is written on wt_vld&wt_rdy&(wt_cnt==i). Accepting wt_cnt==TOUT-1 sets s1_full. wt_rdy = ~s1_full (registered flag).
- promote = s1_full & (Wout_loop_start | wait_wt). On promote, stage1 is copied into the stage2 bank and s1_full clears.
- wait_wt is set by Wout_loop_start when s1_full=0 and cleared by promote.
- Wout_loop_start while wait_wt=1 (double underrun): ignored, and err set.
- Column 0 weights = stage2 bank. Column n≥1 has its own bank, loaded from stage2 slice n when promote delayed n cycles is asserted.
- col_dat loads dat when dat_vld and holds otherwise.
- col_tin[n] = Tin_factor registered once, independently per column, for fanout.
- Deskew: col_res slice n is delayed NCOL-n cycles, then concatenated into dat_o.
- dat_o_vld = dat_vld delayed 1+PE_LAT+NCOL cycles. dat_o_last = (dat_vld&Wout_loop_end) delayed by the same amount.
- flush clears s1_full, wait_wt, the promote delay line and the valid/last pipelines. It does not clear banks, err or data delay lines.
- Reset: all registers, banks and outputs are 0. wt_rdy is 1 out of reset (~s1_full).

## Timing
- Weight word to stage1: 1 cycle.
- Promote: same cycle as the loop start when a set is ready. Otherwise the cycle after s1_full rises (wt_rdy deasserted that cycle).
- col_wt slice n updates n+1 cycles after promote. This matches the one-cycle-per-column data propagation.
- wt_vld with wt_cnt==TOUT-1 in the same cycle as Wout_loop_start with s1_full=0: start sets wait_wt, promote fires next cycle.
- New words may be accepted in the cycle after promote.
- Loop start with stage1 partially filled: treated as underrun-wait, not an error.
- flush has priority over all set conditions in the same cycle.
- Async reset mid-transfer discards everything. The first post-reset set must start at wt_cnt 0.

## Configuration
- SYSTOLIC_STAGE_ERR_EN defined: err is a sticky flag set on double underrun, cleared only by rst_n.
- SYSTOLIC_STAGE_ERR_EN undefined: err is tied to 0 and its logic is removed. Double underrun is still ignored.

## Test plan
Configuration for all scenarios: TOUT=8, TN=2, NCOL=4, PE_LAT=3.
- Load 8 weights (value = 0x10+cnt), then Wout_loop_start 5 cycles later -> promote same cycle, wt_rdy 0→1, col_wt slice 3 updates 4 cycles after start.
- Wout_loop_start first, weights arrive 10 cycles later -> wait_wt=1; promote the cycle after the 8th word; err stays 0.
- Two Wout_loop_start pulses with no weights -> err=1 (macro on) / 0 (macro off); one promote after weights arrive.
- dat_vld burst of 6 with Wout_loop_end on the 6th; col_res column n = n driven -> dat_o_vld high for 6 cycles starting 8 cycles after the first dat_vld; dat_o_last on the 6th; all four slices aligned.
- Second set fully loaded while the first is bound -> wt_rdy=0 until the next Wout_loop_start; no word lost, no overwrite.
- flush mid-weight-load, then reload from wt_cnt 0 -> s1_full reflects only the new set; pipelines emit no stale dat_o_vld.
